an_sec_arbiter: RTL and testbench

Round-robin scheduler that shares one AN-code SEC decoder among `NREQ` requesters. Each requester submits a received codeword `W`. The block grants one requester at a time and issues a start pulse to the decoder. It waits for the decoder's `found`, then returns the decoded `N` to the granted requester. A watchdog aborts a decode that never completes. The block sits between the memory read-return ports and the single `SECdecoder_AWE` instance (A = 83).

---
 rtl/an_sec_arbiter.sv | 126 ++++++++++++
 tb/tb_an_sec_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/an_sec_arbiter.sv
// Round-robin front end that shares one AN-code SEC decoder among NREQ requesters.
// Grants one requester, starts the decoder, returns its result or a watchdog abort.
module an_sec_arbiter #(
  parameter int NREQ    = 4,
  parameter int W_BITS  = 36,
  parameter int N_BITS  = 29,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*W_BITS-1:0] req_w,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [N_BITS-1:0]      rsp_n,
  output logic                   rsp_err,
  output logic                   dec_start,
  output logic [W_BITS-1:0]      dec_w,
  input  logic                   dec_found,
  input  logic [N_BITS-1:0]      dec_n,
  output logic                   busy,
  output logic [15:0]            done_cnt,
  output logic [7:0]             abort_cnt
);

  localparam int               IDX_W    = $clog2(NREQ);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [7:0]       WD_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        wd;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              pick_ok;
  logic [W_BITS-1:0] req_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_arr[g] = req_w[g*W_BITS +: W_BITS];
  end

  // Rotating priority: first asserted request at or after ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    pick    = '0;
    cand    = '0;
    pick_ok = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      wd        <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_n     <= '0;
      rsp_err   <= 1'b0;
      dec_start <= 1'b0;
      dec_w     <= '0;
      busy      <= 1'b0;
      done_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      dec_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            idx       <= pick;
            dec_w     <= req_arr[pick];
            gnt       <= ONE_HOT0 << pick;
            dec_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ptr   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A result in the final watchdog cycle still wins over the abort.
          if (dec_found) begin
            rsp_n     <= dec_n;
            rsp_err   <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            rsp_valid <= ONE_HOT0 << idx;
            state     <= S_RESP;
          end else if (wd == WD_LAST) begin
            rsp_n     <= '0;
            rsp_err   <= 1'b1;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
            rsp_valid <= ONE_HOT0 << idx;
            state     <= S_RESP;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_an_sec_arbiter.sv
// Scoreboard bench for an_sec_arbiter: transaction-level model predicts grants and
// responses, a monitor pops them as the DUT presents them, a decoder model answers.
module tb_an_sec_arbiter;

  localparam int NREQ    = 4;
  localparam int W_BITS  = 36;
  localparam int N_BITS  = 29;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*W_BITS-1:0] req_w;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [N_BITS-1:0]      rsp_n;
  logic                   rsp_err;
  logic                   dec_start;
  logic [W_BITS-1:0]      dec_w;
  logic                   dec_found;
  logic [N_BITS-1:0]      dec_n;
  logic                   busy;
  logic [15:0]            done_cnt;
  logic [7:0]             abort_cnt;

  an_sec_arbiter #(.NREQ(NREQ), .W_BITS(W_BITS), .N_BITS(N_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_w(req_w), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_n(rsp_n), .rsp_err(rsp_err), .dec_start(dec_start), .dec_w(dec_w),
    .dec_found(dec_found), .dec_n(dec_n), .busy(busy), .done_cnt(done_cnt),
    .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester side: true data value and transmitted codeword per requester.
  logic [W_BITS-1:0] cw    [NREQ];
  logic [N_BITS-1:0] ntrue [NREQ];

  always_comb begin
    req_w = '0;
    for (int i = 0; i < NREQ; i++) req_w[i*W_BITS +: W_BITS] = cw[i];
  end

  typedef struct { int idx; int cyc; } gnt_e;
  typedef struct {
    int idx; logic [N_BITS-1:0] n; logic err; int cyc; logic [15:0] done; logic [7:0] abrt;
  } rsp_e;
  typedef struct { int lat; logic [W_BITS-1:0] w; } plan_e;

  gnt_e  gq [$];
  rsp_e  rq [$];
  plan_e pq [$];
  int    glog [$];

  // Reference model state (transaction level).
  int m_ptr   = 0;
  int m_idle  = 0;
  int m_done  = 0;
  int m_abort = 0;
  int b_lo    = -1;
  int b_hi    = -2;
  int lat_sel = -1;

  // Model: when the arbiter is free and any request is up, predict the grant,
  // choose the decoder latency, and predict the response and its cycle.
  task automatic model_step();
    int j, lat, g, r;
    rsp_e re;
    if (rst) begin
      gq.delete(); rq.delete(); pq.delete();
      m_ptr = 0; m_idle = cyc + 1; m_done = 0; m_abort = 0; b_lo = -1; b_hi = -2;
      return;
    end
    if (cyc < m_idle || req == '0) return;
    j = -1;
    for (int k = 0; k < NREQ; k++)
      if (j < 0 && req[(m_ptr + k) % NREQ]) j = (m_ptr + k) % NREQ;
    if (lat_sel >= 0) lat = lat_sel;
    else if ($urandom_range(0, 9) == 0) lat = TIMEOUT + $urandom_range(0, 2);
    else lat = $urandom_range(0, TIMEOUT - 1);
    g = cyc + 1;
    re.idx = j;
    if (lat < TIMEOUT) begin
      r = g + 2 + lat;
      m_done++;
      re.n = ntrue[j]; re.err = 1'b0;
    end else begin
      r = g + 1 + TIMEOUT;
      if (m_abort < 255) m_abort++;
      re.n = '0; re.err = 1'b1;
    end
    re.cyc = r; re.done = 16'(m_done); re.abrt = 8'(m_abort);
    gq.push_back('{idx: j, cyc: g});
    pq.push_back('{lat: lat, w: cw[j]});
    rq.push_back(re);
    m_ptr = (j + 1) % NREQ; m_idle = r + 1; b_lo = g; b_hi = r;
  endtask

  initial forever begin
    @(negedge clk); #1;
    model_step();
  end

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  task automatic monitor_step();
    gnt_e ge;
    rsp_e re;
    logic [NREQ-1:0] oh;
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      check("gnt_missing_cycle", 64'(cyc), 64'(gq[0].cyc));
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      check("rsp_missing_cycle", 64'(cyc), 64'(rq[0].cyc));
      void'(rq.pop_front());
    end
    check("busy", busy, 64'(cyc >= b_lo && cyc <= b_hi));
    if (gnt != '0 || dec_start) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
      if (gq.size() == 0) check("gnt_unexpected", {gnt, dec_start}, '0);
      else begin
        ge = gq.pop_front();
        oh = '0; oh[ge.idx] = 1'b1;
        check("gnt_vec", gnt, oh);
        check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        check("dec_start", dec_start, 1'b1);
      end
    end
    if (rsp_valid != '0) begin
      if (rq.size() == 0) check("rsp_unexpected", rsp_valid, '0);
      else begin
        re = rq.pop_front();
        oh = '0; oh[re.idx] = 1'b1;
        check("rsp_vec", rsp_valid, oh);
        check("rsp_cycle", 64'(cyc), 64'(re.cyc));
        check("rsp_n", rsp_n, re.n);
        check("rsp_err", rsp_err, re.err);
        check("done_cnt", done_cnt, re.done);
        check("abort_cnt", abort_cnt, re.abrt);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // AN-code (A=83) single-error-correcting decoder model, syndrome search.
  function automatic logic [N_BITS-1:0] an_decode(input logic [W_BITS-1:0] w);
    longint unsigned wv, r, p, v;
    wv = 64'(w);
    r  = wv % 83;
    v  = wv;
    if (r != 0)
      for (int j = 0; j < W_BITS; j++) begin
        p = 64'd1 << j;
        if (p % 83 == r) begin v = wv - p; break; end
        if (83 - (p % 83) == r) begin v = wv + p; break; end
      end
    return N_BITS'(v / 83);
  endfunction

  int                found_at = -1;
  int                hold_s   = -1;
  int                hold_e   = -2;
  logic [W_BITS-1:0] hold_w   = '0;
  logic [N_BITS-1:0] resp_n   = '0;

  initial begin
    dec_found = 1'b0;
    dec_n     = '0;
    forever begin
      @(posedge clk); #1;
      dec_found = (cyc == found_at);
      dec_n     = dec_found ? resp_n : '0;
    end
  end

  initial forever begin
    plan_e p;
    @(negedge clk); #2;
    if (rst) begin
      found_at = -1; hold_e = -2;
    end else begin
      if (cyc > hold_s && cyc <= hold_e) check("dec_w_hold", dec_w, hold_w);
      if (dec_start) begin
        if (pq.size() == 0) check("start_without_plan", dec_start, 1'b0);
        else begin
          p = pq.pop_front();
          check("dec_w_start", dec_w, p.w);
          found_at = cyc + 1 + p.lat;
          hold_s   = cyc;
          hold_e   = (p.lat < TIMEOUT) ? found_at : cyc + TIMEOUT;
          hold_w   = p.w;
          resp_n   = an_decode(dec_w);
        end
      end
    end
  end

  // Stimulus helpers.
  logic [NREQ-1:0] last_gnt  = '0;
  logic            last_busy = 1'b0;

  task automatic tick();
    @(negedge clk);
    last_gnt  = gnt;
    last_busy = busy;
    @(posedge clk); #1;
  endtask

  task automatic raise(input int i, input logic [N_BITS-1:0] n, input int e);
    logic [W_BITS-1:0] w;
    w = W_BITS'(83) * W_BITS'(n);
    if (e >= 0) w = w + (W_BITS'(1) << e);
    ntrue[i] = n;
    cw[i]    = w;
    req[i]   = 1'b1;
  endtask

  task automatic raise_rand(input int i);
    int e;
    e = $urandom_range(0, 35);
    raise(i, N_BITS'($urandom & 32'h0FFF_FFFF), (e > 34) ? -1 : e);
  endtask

  task automatic wait_gnt(input int i);
    int k = 0;
    do begin tick(); k++; end while (!last_gnt[i] && k < 60);
    check($sformatf("gnt_seen_%0d", i), last_gnt[i], 1'b1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin tick(); k++; end while (last_busy && k < 60);
    check("idle_reached", last_busy, 1'b0);
  endtask

  task automatic do_req(input int i, input logic [N_BITS-1:0] n, input int e, input int lat);
    lat_sel = lat;
    raise(i, n, e);
    wait_gnt(i);
    req[i] = 1'b0;
    wait_idle();
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_gnt"}, gnt, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_n"}, rsp_n, '0);
    check({tag, "_rsp_err"}, rsp_err, '0);
    check({tag, "_dec_start"}, dec_start, '0);
    check({tag, "_dec_w"}, dec_w, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_done_cnt"}, done_cnt, '0);
    check({tag, "_abort_cnt"}, abort_cnt, '0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int fair_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NREQ; i++) begin cw[i] = '0; ntrue[i] = '0; end
    repeat (2) tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Clean codeword, then a corrected single-bit error on requester 2.
    do_req(0, N_BITS'(100), -1, 4);
    do_req(2, N_BITS'(100), 3, 4);

    // Fairness from a freshly reset pointer with every request held.
    pulse_reset();
    check_zero_outputs("reset2");
    glog.delete();
    lat_sel = 2;
    for (int i = 0; i < NREQ; i++) raise(i, N_BITS'(200 + i), -1);
    for (int k = 0; k < 80 && glog.size() < 5; k++) tick();
    req = '0;
    wait_idle();
    check("fair_count", 64'(glog.size()), 64'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      check($sformatf("fair_order_%0d", k), 64'(glog[k]), 64'(fair_exp[k]));

    // Watchdog abort, then a late result that must be discarded.
    do_req(0, N_BITS'(321), -1, TIMEOUT + 3);
    repeat (8) tick();

    // Reset in the third WAIT cycle of a grant to requester 2.
    lat_sel = 10;
    raise(2, N_BITS'(777), -1);
    wait_gnt(2);
    req[2] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("midwait");
    lat_sel = 2;
    raise(0, N_BITS'(11), -1);
    raise(3, N_BITS'(33), 5);
    repeat (2) tick();
    check("ptr_after_reset", last_gnt, 4'b0001);
    req[0] = 1'b0;
    wait_gnt(3);
    req[3] = 1'b0;
    wait_idle();

    // Requester 1 pulses for one cycle while requester 0 is being served.
    lat_sel = 6;
    raise(0, N_BITS'(55), -1);
    wait_gnt(0);
    req[0] = 1'b0;
    tick();
    raise(1, N_BITS'(66), -1);
    tick();
    req[1] = 1'b0;
    wait_idle();
    repeat (3) tick();

    // Randomized traffic: arrivals, withdrawals, re-requests, random latencies.
    lat_sel = -1;
    for (int t = 0; t < 1500; t++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) begin
          if ($urandom_range(0, 3) == 0) raise_rand(i);
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) raise_rand(i);
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle();
    repeat (5) tick();

    // Enough consecutive aborts to drive the abort counter into saturation.
    lat_sel = TIMEOUT + 1;
    raise(3, N_BITS'(5), -1);
    for (int k = 0; k < 260 * (TIMEOUT + 4) + 10; k++) tick();
    req = '0;
    wait_idle();
    repeat (5) tick();
    @(negedge clk);
    check("abort_saturated", abort_cnt, 8'd255);
    check("gnt_queue_drained", 64'(gq.size()), 64'd0);
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
